wrap_saed32_dp_array: RTL
=========================

// Module: wrap_saed32_dp_array
// PURPOSE
//   Parametrised dual-port SRAM array built from a ROWS x COLS grid of SAED32 SRAM2RW32X4 macros (32 words x 4 bits).
//   Two independent synchronous ports on one clock. Per-nibble write enables.
//   Registered bank select, optional output register, read-valid strobes.
//   Same-address collision detection with port-0 priority.
//   Drop-in memory primitive for generated memory subsystems needing >32x4 dual-port storage.
// PARAMETERS
//   WIDTH    16  data width in bits; multiple of 4; COLS = WIDTH/4
//   DEPTH    128 words; multiple of 32; ROWS = DEPTH/32
//   AW       7   address width; must equal clog2(DEPTH)
//   OUT_REG  0   0: read latency 1 cycle; 1: extra output register, latency 2
// PORTS
//   CLK    in   1        clock; all macros share it
//   RST    in   1        asynchronous, active-high reset
//   CEp    in   1        port p enable, active-high (p = 0,1)
//   WEp    in   1        port p write, active-high; read when CEp=1, WEp=0
//   Ap     in   AW       port p word address
//   Dp     in   WIDTH    port p write data
//   WEMp   in   WIDTH/4  port p nibble write enable; bit k writes D[4k+3:4k]
//   Qp     out  WIDTH    port p read data; 0 whenever QVp=0
//   QVp    out  1        port p read data valid
//   COLL   out  1        registered collision flag, aligned with the colliding cycle's read data
// BEHAVIOUR
//   - Address split: A[4:0] selects the macro word; A[AW-1:5] selects the macro row.
//   - Only the selected row's macros get CSB low; others stay deselected.
//   - Writes:
//     - Column k of the selected row writes only if CEp & WEp & WEMp[k].
//     - Columns with WEMp[k]=0 are neither written nor read.
//     - WEMp = 0 with WEp = 1 is a no-op; QVp stays low.
//   - Reads:
//     - Data arrives at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1) after issue at edge N.
//     - QVp is high for exactly one cycle per issued read.
//     - Back-to-back reads are fully pipelined: one per cycle per port.
//   - Row select for the output mux is registered per port at issue.
//     With OUT_REG=1 it is carried one extra stage alongside the data.
//   - Collision: both ports enabled, A0 == A1, and at least one port writing.
//     - W/W: the port-1 write is suppressed (port 0 wins). COLL=1 one cycle later.
//     - R/W: COLL=1 on the reader's valid cycle.
//       The read data comes from the macro and is undefined unless WRAP_SAED32_BYPASS_EN is set.
//     - R/R to the same address is legal. COLL=0.
//   - Reset (RST=1, async):
//     - All CSB forced high and all WEB forced high: no macro access while reset is high.
//     - QV0, QV1 and COLL clear to 0 immediately.
//     - Pipeline stages and row-select registers clear to 0. Q0 and Q1 read 0.
//   - Reset asserted mid-read: the in-flight read is dropped and its QV never asserts.
//     The first access is accepted on the first rising edge after RST deasserts.
//   - Address wrap: none. AW covers DEPTH exactly; out-of-range addresses cannot occur.
// CONFIGURATION
//   WRAP_SAED32_BYPASS_EN
//   - Defined:
//     - On an R/W collision, the reader's nibbles with the writer's WEM bit set return the writer's D.
//       This data is captured at issue.
//     - Nibbles with the WEM bit clear return the macro read data.
//     - COLL still asserts.
//   - Undefined:
//     - No forwarding; the colliding read nibbles are undefined.
//     - The bench must mask the colliding nibbles when COLL=1.
// STRUCTURE
//   - Shared package saed32_mem_pkg holds:
//     - MACRO_W=4, MACRO_D=32, MACRO_AW=5
//     - the ROWS/COLS derivation functions
//     - the access-type enum {IDLE, RD, WR}
//   - Sub-module wrap_saed32_dp_port_ctrl, instantiated once per port, handles:
//     - row decode and CSB/WEB/OEB generation
//     - the read pipeline, row-select register, QV generation and output mux
//   - The top level holds the macro generate grid, the collision compare and the bypass capture.
// TESTING
//   1. Reset: RST=1 mid-read on port 0 -> QV0 stays 0; Q0=0; COLL=0. The first read after release returns the data written before reset.
//   2. Full sweep, WIDTH=16, DEPTH=128:
//      - Port 0 writes A=0..127 with D=A*0x0101. Port 1 reads back-to-back.
//      - Expect Q1=A*0x0101 with QV1=1 at latency 1 (OUT_REG=0) and at latency 2 (OUT_REG=1).
//   3. Nibble mask: write 0xFFFF to A=0x25, then write 0x1234 with WEM=4'b0101 -> read returns 0xF2F4.
//   4. W/W collision: both ports write A=0x40, D0=0xAAAA, D1=0x5555 -> COLL=1 for one cycle; read of 0x40 returns 0xAAAA.
//   5. R/W collision: port 0 writes 0xBEEF with WEM=4'b1100 to A=0x10, which held 0x0000. Port 1 reads A=0x10 in the same cycle.
//      - Bypass build: Q1=0xBE00 and COLL=1.
//      - Non-bypass build: COLL=1, data ignored.
//   6. Row boundary: reads at A=31 and A=32 alternating on port 1 -> correct per-row data every cycle, with no stale row select.

Source files
------------

// File: rtl/saed32_mem_pkg.sv
// saed32_mem_pkg: SAED32 32x4 dual-port macro geometry, grid sizing helpers and access types
package saed32_mem_pkg;
  localparam int MACRO_W = 4;
  localparam int MACRO_D = 32;
  localparam int MACRO_AW = 5;
  typedef enum logic [1:0] {IDLE, RD, WR} acc_t;
  function automatic int rows_of(input int depth);
    return depth / MACRO_D;
  endfunction
  function automatic int cols_of(input int width);
    return width / MACRO_W;
  endfunction
endpackage

// File: rtl/SRAM2RW32X4.sv
// SRAM2RW32X4: behavioural stand-in for the SAED32 32x4 dual-port macro (registered read, OEB-gated outputs)
module SRAM2RW32X4 (
  input  logic [4:0] A1,
  input  logic [4:0] A2,
  input  logic       CE1,
  input  logic       CE2,
  input  logic       WEB1,
  input  logic       WEB2,
  input  logic       OEB1,
  input  logic       OEB2,
  input  logic       CSB1,
  input  logic       CSB2,
  input  logic [3:0] I1,
  input  logic [3:0] I2,
  output logic [3:0] O1,
  output logic [3:0] O2
);
  logic [3:0] mem [32];
  logic [3:0] r1, r2;
  logic unused_ce2;
  // both port clocks are tied together by the wrapper, so one process models both ports
  assign unused_ce2 = CE2;
  always_ff @(posedge CE1) begin
    if (!CSB2 && !WEB2) mem[A2] <= I2;
    if (!CSB1 && !WEB1) mem[A1] <= I1;
    if (!CSB1 && WEB1) r1 <= mem[A1];
    if (!CSB2 && WEB2) r2 <= mem[A2];
  end
  assign O1 = OEB1 ? '0 : r1;
  assign O2 = OEB2 ? '0 : r2;
endmodule

// File: rtl/wrap_saed32_dp_port_ctrl.sv
// wrap_saed32_dp_port_ctrl: one port's row decode, macro strobes, read pipeline, QV and output mux
module wrap_saed32_dp_port_ctrl
  import saed32_mem_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW = 7,
  parameter int OUT_REG = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      ce,
  input  logic                                      we,
  input  logic [AW-1:0]                             a,
  input  logic [WIDTH/MACRO_W-1:0]                  wem,
  input  logic [rows_of(DEPTH)*WIDTH-1:0]           mo,
  input  logic [WIDTH-1:0]                          fm,
  input  logic [WIDTH-1:0]                          fd,
  output logic [rows_of(DEPTH)*cols_of(WIDTH)-1:0] csb,
  output logic                                      web,
  output logic                                      oeb,
  output logic [WIDTH-1:0]                          q,
  output logic                                      qv
);
  localparam int ROWS = rows_of(DEPTH);
  localparam int COLS = cols_of(WIDTH);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  acc_t acc;
  logic [RW-1:0] row, r1;
  logic v1;
  logic [WIDTH-1:0] d1;
  assign acc = !ce ? IDLE : we ? WR : RD;
  assign row = RW'(a >> MACRO_AW);
  assign web = rst | (acc != WR);
  assign oeb = rst;
  // masked-off columns stay deselected on writes so they are neither written nor read
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign csb[r*COLS+c] = rst | (acc == IDLE) | (row != RW'(r)) | ((acc == WR) & !wem[c]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else begin
      v1 <= acc == RD;
      if (acc == RD) r1 <= row;
    end
  end
  assign d1 = (mo[int'(r1)*WIDTH +: WIDTH] & ~fm) | (fd & fm);
  if (OUT_REG != 0) begin : g_oreg
    logic v2;
    logic [WIDTH-1:0] q2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2 <= 1'b0;
        q2 <= '0;
      end else begin
        v2 <= v1;
        q2 <= v1 ? d1 : '0;
      end
    end
    assign q = q2;
    assign qv = v2;
  end else begin : g_comb
    assign q = v1 ? d1 : '0;
    assign qv = v1;
  end
endmodule

// File: rtl/wrap_saed32_dp_array.sv
// wrap_saed32_dp_array: dual-port SRAM from a grid of SAED32 32x4 macros, collision flag, port-0 write priority
// WRAP_SAED32_BYPASS_EN forwards the writer's data to a same-address reader on an R/W collision.
module wrap_saed32_dp_array
  import saed32_mem_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW = 7,
  parameter int OUT_REG = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CE0,
  input  logic                     WE0,
  input  logic [AW-1:0]            A0,
  input  logic [WIDTH-1:0]         D0,
  input  logic [WIDTH/MACRO_W-1:0] WEM0,
  input  logic                     CE1,
  input  logic                     WE1,
  input  logic [AW-1:0]            A1,
  input  logic [WIDTH-1:0]         D1,
  input  logic [WIDTH/MACRO_W-1:0] WEM1,
  output logic [WIDTH-1:0]         Q0,
  output logic                     QV0,
  output logic [WIDTH-1:0]         Q1,
  output logic                     QV1,
  output logic                     COLL
);
  localparam int ROWS = rows_of(DEPTH);
  localparam int COLS = cols_of(WIDTH);
  logic coll, ww, rw0, rw1, ce1, web0, web1, oeb0, oeb1, cw, cr1;
  logic [ROWS*COLS-1:0] csb0, csb1;
  logic [ROWS*WIDTH-1:0] mo0, mo1;
  logic [WIDTH-1:0] fm0, fd0, fm1, fd1;
  assign coll = CE0 & CE1 & (A0 == A1) & (WE0 | WE1);
  assign ww = coll & WE0 & WE1;
  assign rw0 = coll & !WE0;
  assign rw1 = coll & !WE1;
  assign ce1 = CE1 & !ww;
`ifdef WRAP_SAED32_BYPASS_EN
  logic [WIDTH-1:0] m0, m1;
  for (genvar c = 0; c < COLS; c++) begin : g_wm
    assign m0[c*MACRO_W +: MACRO_W] = {MACRO_W{WEM0[c]}};
    assign m1[c*MACRO_W +: MACRO_W] = {MACRO_W{WEM1[c]}};
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fm0 <= '0;
      fd0 <= '0;
      fm1 <= '0;
      fd1 <= '0;
    end else begin
      fm0 <= rw0 ? m1 : '0;
      fd0 <= D1;
      fm1 <= rw1 ? m0 : '0;
      fd1 <= D0;
    end
  end
`else
  assign fm0 = '0;
  assign fd0 = '0;
  assign fm1 = '0;
  assign fd1 = '0;
`endif
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cw <= 1'b0;
      cr1 <= 1'b0;
    end else begin
      cw <= ww;
      cr1 <= rw0 | rw1;
    end
  end
  // W/W flags one cycle later; R/W flags on the reader's valid cycle
  if (OUT_REG != 0) begin : g_coll2
    logic cr2;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) cr2 <= 1'b0;
      else cr2 <= cr1;
    end
    assign COLL = cw | cr2;
  end else begin : g_coll1
    assign COLL = cw | cr1;
  end
  wrap_saed32_dp_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .OUT_REG(OUT_REG)) u_p0 (
    .clk(CLK), .rst(RST), .ce(CE0), .we(WE0), .a(A0), .wem(WEM0), .mo(mo0), .fm(fm0), .fd(fd0),
    .csb(csb0), .web(web0), .oeb(oeb0), .q(Q0), .qv(QV0)
  );
  wrap_saed32_dp_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .OUT_REG(OUT_REG)) u_p1 (
    .clk(CLK), .rst(RST), .ce(ce1), .we(WE1), .a(A1), .wem(WEM1), .mo(mo1), .fm(fm1), .fd(fd1),
    .csb(csb1), .web(web1), .oeb(oeb1), .q(Q1), .qv(QV1)
  );
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      SRAM2RW32X4 u_mac (
        .A1(A0[MACRO_AW-1:0]), .A2(A1[MACRO_AW-1:0]), .CE1(CLK), .CE2(CLK),
        .WEB1(web0), .WEB2(web1), .OEB1(oeb0), .OEB2(oeb1),
        .CSB1(csb0[r*COLS+c]), .CSB2(csb1[r*COLS+c]),
        .I1(D0[c*MACRO_W +: MACRO_W]), .I2(D1[c*MACRO_W +: MACRO_W]),
        .O1(mo0[r*WIDTH+c*MACRO_W +: MACRO_W]), .O2(mo1[r*WIDTH+c*MACRO_W +: MACRO_W])
      );
    end
  end
endmodule
